// File: rtl/vga_image_viewer_pio_arbiter.sv
// ---------------------------------------------------------------------------
// vga_image_viewer_pio_arbiter
//
// Round-robin read arbiter letting two Avalon-MM masters share the read-only
// input PIO slave. Master 0 is the Nios CPU. Master 1 is the pixel-fetch
// engine.
//
// The arbiter issues at most one read per cycle. Each accepted read is
// tracked through a READ_LATENCY-deep {valid, id} pipeline, and the returning
// word is steered back to the master that issued it.
//
// Parameters:
//   ADDR_W        slave address width
//   DATA_W        data width
//   READ_LATENCY  slave cycles from accepted read to valid s_readdata (1..4)
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   m0_read / m0_address         master 0 request (held until accepted)
//   m0_waitrequest               master 0 stall
//   m0_readdata/_readdatavalid   master 0 return data and strobe
//   m1_*                         same for master 1
//   s_read / s_address           read issued to the slave
//   s_readdata                   slave registered read data
//   stat_grants0/1               accepted-read counters per master
//   stat_conflicts               cycles in which both masters requested
//
// Optional feature macro: ARB_STATS_EN
//   When defined, the three stat counters saturate at 16'hFFFF.
//   When undefined, the stat ports are tied to zero.
// ---------------------------------------------------------------------------
module vga_image_viewer_pio_arbiter #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_read,
   input  logic [ADDR_W-1:0] m0_address,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic              m1_read,
   input  logic [ADDR_W-1:0] m1_address,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic              s_read,
   output logic [ADDR_W-1:0] s_address,
   input  logic [DATA_W-1:0] s_readdata,
   output logic [15:0]       stat_grants0,
   output logic [15:0]       stat_grants1,
   output logic [15:0]       stat_conflicts
);

   // last_grant_r holds the index of the most recently accepted master.
   // Its reset value of 1 lets master 0 win the first conflict.
   logic                    last_grant_r;
   logic                    grant0_s;
   logic                    grant1_s;
   logic                    grant_any_s;
   logic                    grant_id_s;
   logic [READ_LATENCY-1:0] pipe_valid_r;
   logic [READ_LATENCY-1:0] pipe_id_r;
   logic                    ret_valid_s;
   logic                    ret_id_s;

   // Grant selection and the master/slave handshake signals.
   // While reset is asserted nothing is granted, so both requesting
   // masters see waitrequest.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (reset_n) begin
         if (m0_read && m1_read) begin
            if (last_grant_r) begin
               grant0_s = 1'b1;
            end else begin
               grant1_s = 1'b1;
            end
         end else begin
            grant0_s = m0_read;
            grant1_s = m1_read;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
      grant_any_s    = grant0_s | grant1_s;
      grant_id_s     = grant1_s;
      m0_waitrequest = m0_read & ~grant0_s;
      m1_waitrequest = m1_read & ~grant1_s;
      s_read         = grant_any_s;
      if (grant1_s) begin
         s_address = m1_address;
      end else if (grant0_s) begin
         s_address = m0_address;
      end else begin
         s_address = {ADDR_W{1'b0}};
      end
   end

   // The last pipeline stage tells which master the word on s_readdata
   // belongs to at the coming edge.
   always_comb begin
      ret_valid_s = pipe_valid_r[READ_LATENCY-1];
      ret_id_s    = pipe_id_r[READ_LATENCY-1];
   end

   // Round-robin pointer and in-flight tracking pipeline.
   // The pipeline shifts every cycle; it has no back-pressure.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_grant_r <= 1'b1;
         pipe_valid_r <= {READ_LATENCY{1'b0}};
         pipe_id_r    <= {READ_LATENCY{1'b0}};
      end else begin
         pipe_valid_r[0] <= grant_any_s;
         pipe_id_r[0]    <= grant_id_s;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_r[i] <= pipe_valid_r[i-1];
            pipe_id_r[i]    <= pipe_id_r[i-1];
         end
         if (grant_any_s) begin
            last_grant_r <= grant_id_s;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Return path: capture the slave word for the owning master and strobe
   // its valid. The other master's data holds its previous value.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         m0_readdata      <= {DATA_W{1'b0}};
         m1_readdata      <= {DATA_W{1'b0}};
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
      end else begin
         m0_readdatavalid <= ret_valid_s & ~ret_id_s;
         m1_readdatavalid <= ret_valid_s & ret_id_s;
         if (ret_valid_s && !ret_id_s) begin
            m0_readdata <= s_readdata;
         end else begin
            m0_readdata <= m0_readdata;
         end
         if (ret_valid_s && ret_id_s) begin
            m1_readdata <= s_readdata;
         end else begin
            m1_readdata <= m1_readdata;
         end
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] grants0_r;
   logic [15:0] grants1_r;
   logic [15:0] conflicts_r;

   // Saturating statistics counters. They clear only on reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grants0_r   <= 16'h0000;
         grants1_r   <= 16'h0000;
         conflicts_r <= 16'h0000;
      end else begin
         if (grant0_s && (grants0_r != 16'hFFFF)) begin
            grants0_r <= grants0_r + 16'd1;
         end else begin
            grants0_r <= grants0_r;
         end
         if (grant1_s && (grants1_r != 16'hFFFF)) begin
            grants1_r <= grants1_r + 16'd1;
         end else begin
            grants1_r <= grants1_r;
         end
         if (m0_read && m1_read && (conflicts_r != 16'hFFFF)) begin
            conflicts_r <= conflicts_r + 16'd1;
         end else begin
            conflicts_r <= conflicts_r;
         end
      end
   end

   assign stat_grants0   = grants0_r;
   assign stat_grants1   = grants1_r;
   assign stat_conflicts = conflicts_r;
`else
   assign stat_grants0   = 16'h0000;
   assign stat_grants1   = 16'h0000;
   assign stat_conflicts = 16'h0000;
`endif

endmodule

// File: doc/vga_image_viewer_pio_arbiter.md
# vga_image_viewer_pio_arbiter

Two-master read arbiter for the VGA image viewer's 32-bit Avalon-MM input PIO (2-bit address, registered readdata, fixed read latency, no waitrequest). It lets the Nios CPU (master 0) and the pixel-fetch engine (master 1) share that one read-only slave. The block arbitrates round-robin and issues at most one read per cycle. It tracks in-flight reads in a latency pipeline and routes each returning word back to the master that issued it.

## Interface
Parameters:
- ADDR_W, 2, slave address width
- DATA_W, 32, data width
- READ_LATENCY, 1, slave cycles from accepted read to valid s_readdata (1..4)

Ports:
- clk  in  1  single clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- m0_read  in  1  master 0 read request, held until accepted
- m0_address  in  ADDR_W  master 0 address
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 return data
- m0_readdatavalid  out  1  master 0 return strobe
- m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid: same as m0_* for master 1
- s_read  out  1  read issued to slave
- s_address  out  ADDR_W  slave address
- s_readdata  in  DATA_W  slave registered data
- stat_grants0, stat_grants1  out  16  accepted-read counters (see Configuration)
- stat_conflicts  out  16  cycles in which both masters requested

## Operation
- Grant (combinational):
  - Only one mi_read high: that master is granted.
  - Both high: the master not equal to last_grant is granted.
  - Neither high: no grant.
- last_grant register: reset value 1, so m0 wins the first conflict. Updated to the granted index on every accepted read.
- mi_waitrequest = mi_read & ~grant_i. It is 0 when mi_read is low. The losing master holds its read and address.
- s_read = any grant. s_address = granted master's address, or 0 when there is no grant.
- Acceptance: the edge at which mi_read=1 and mi_waitrequest=0.
- In-flight pipeline: READ_LATENCY stages of {valid, id}. Stage 0 loads {s_read, granted index} at each edge. Entries shift every cycle, with no back-pressure.
- Return: when the last stage's valid is 1, the next edge does two things:
  - registers s_readdata into m{id}_readdata;
  - pulses m{id}_readdatavalid high for one cycle.
- The other master's readdata holds its previous value, and its valid stays 0.
- Responses return strictly in issue order. Back-to-back accepted reads give back-to-back valid pulses.
- No FSM beyond the pointer and pipeline. The block is fully pipelined at one read per cycle.

## Timing
- Acceptance at edge k: s_readdata is sampled at edge k+READ_LATENCY, and mi_readdatavalid is high in the cycle following that edge.
- Total latency from acceptance to valid: READ_LATENCY+1 cycles (2 at the default).
- Reset values (reset_n=0 at an edge): all pipeline valids 0, last_grant=1, m0/m1_readdata=0, readdatavalid=0, all stat counters 0.
- While reset_n=0:
  - s_read is forced 0;
  - both waitrequests are forced 1 if the corresponding read is high;
  - no acceptance occurs.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid pulse is produced for them afterwards.
- Simultaneous new acceptance and return in the same cycle: both proceed independently.
- Sustained contention: grants alternate m0, m1, m0, ... every cycle, so no master waits more than 1 cycle.

## Configuration
- ARB_STATS_EN defined:
  - stat_grants0 and stat_grants1 increment on each acceptance by the respective master.
  - stat_conflicts increments on each cycle with m0_read & m1_read & reset_n.
  - All three saturate at 16'hFFFF and clear only on reset.
- ARB_STATS_EN undefined: the stat ports remain but are tied to 0, and no counter logic is synthesized.

## Test plan
- Single master: m0_read=1, m0_address=0, s_readdata=32'hDEADBEEF. Expect m0_waitrequest=0, s_read=1 at edge 0, m0_readdatavalid=1 with m0_readdata=32'hDEADBEEF after 2 edges, and no m1_readdatavalid.
- Contention from reset: both masters hold read for 4 cycles. Expect grant order m0,m1,m0,m1; each waitrequest high on alternate cycles; 4 valid pulses in the same order; stat_conflicts=4 and stat_grants0=stat_grants1=2 with ARB_STATS_EN.
- Data routing: s_readdata steps 1,2,3,4 per cycle under alternating grants. Expect m0 to receive 1,3 and m1 to receive 2,4. Non-targeted readdata holds its last value.
- Reset mid-flight: accept an m1 read, then pull reset_n low for 1 cycle before the return. Expect no m1_readdatavalid, readdata=0, and the next conflict granted to m0.
- READ_LATENCY=3: back-to-back m0 reads at edges 0,1,2. Expect valid pulses after edges 3,4,5, in order, with matching data.
- Saturation (ARB_STATS_EN): force 70000 m0 grants. Expect stat_grants0=16'hFFFF and no wrap.
